// File: rtl/calc_alu_if.sv
// Handshake and data bundle between the keypad/control FSM (master) and
// the calculator ALU (slave).
interface calc_alu_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       op;
    logic             start;
    logic             clear;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        output operand_a, operand_b, op, start, clear,
        input  busy, done, result, error
    );

    modport slave (
        input  operand_a, operand_b, op, start, clear,
        output busy, done, result, error
    );
endinterface

// File: rtl/calc_alu.sv
// Sequential calculator ALU: add/sub in one step, shift-add multiply and
// restoring divide one bit per cycle. The result is saturated to MAX_VALUE
// and held for the display until the next done or an idle clear.
module calc_alu #(
    parameter int WIDTH     = 14,
    parameter int MAX_VALUE = 9999
) (
    input  logic        clk,
    input  logic        reset,
    calc_alu_if.slave   bus
);
    localparam int                   CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_VALUE);
    localparam logic [2*WIDTH-1:0]   MAX_P = (2*WIDTH)'(MAX_VALUE);

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, FINISH} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;      // operand a; becomes the quotient during DIV
    logic [WIDTH-1:0]   b_q;      // operand b; shifted right as multiplier during MUL
    logic [1:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   tmp_res;  // add/sub outcome, staged for FINISH
    logic               tmp_err;  // add/sub error, or divide-by-zero flag
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   res_q;
    logic               err_q;

    logic [WIDTH-1:0]   a_clamp;
    logic [WIDTH-1:0]   b_clamp;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   rem_sub;

    assign a_clamp = (bus.operand_a > MAX_W) ? MAX_W : bus.operand_a;
    assign b_clamp = (bus.operand_b > MAX_W) ? MAX_W : bus.operand_b;
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    // Partial remainder shifted left with the next dividend bit (MSB first).
    // The remainder is always below b, so it fits in WIDTH bits.
    assign shifted = {rem, a_q[WIDTH-1]};
    assign rem_sub = WIDTH'(shifted - {1'b0, b_q});

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.error  = err_q;

    // Control FSM and datapath; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            rem     <= '0;
            tmp_res <= '0;
            tmp_err <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= a_clamp;
                        b_q     <= b_clamp;
                        op_q    <= bus.op;
                        cnt     <= '0;
                        prod    <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a_clamp};
                        rem     <= '0;
                        tmp_err <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!bus.op[1])     state <= ADDSUB;
                        else if (!bus.op[0]) state <= MUL;
                        else                 state <= DIV;
                    end else if (bus.clear) begin
                        res_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                ADDSUB: begin
                    if (!op_q[0]) begin
                        if (sum > {1'b0, MAX_W}) begin
                            tmp_res <= MAX_W;
                            tmp_err <= 1'b1;
                        end else begin
                            tmp_res <= sum[WIDTH-1:0];
                            tmp_err <= 1'b0;
                        end
                    end else begin
                        if (a_q < b_q) begin
                            tmp_res <= '0;
                            tmp_err <= 1'b1;
                        end else begin
                            tmp_res <= a_q - b_q;
                            tmp_err <= 1'b0;
                        end
                    end
                    state <= FINISH;
                end
                MUL: begin
                    if (b_q[0]) prod <= prod + mcand;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= FINISH;
                end
                DIV: begin
                    // Zero divisor is caught before any iteration runs.
                    if (cnt == '0 && b_q == '0) begin
                        tmp_err <= 1'b1;
                        state   <= FINISH;
                    end else begin
                        if (shifted >= {1'b0, b_q}) begin
                            rem <= rem_sub;
                            a_q <= {a_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            a_q <= {a_q[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= FINISH;
                    end
                end
                FINISH: begin
                    case (op_q)
                        2'b10: begin
                            if (prod > MAX_P) begin
                                res_q <= MAX_W;
                                err_q <= 1'b1;
                            end else begin
                                res_q <= prod[WIDTH-1:0];
                                err_q <= 1'b0;
                            end
                        end
                        2'b11: begin
                            res_q <= tmp_err ? '0 : a_q;
                            err_q <= tmp_err;
                        end
                        default: begin
                            res_q <= tmp_res;
                            err_q <= tmp_err;
                        end
                    endcase
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: expected results come from an integer
// model, are queued at issue and popped when done pulses.
module tb_calc_alu;
    localparam int W = 14;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    calc_alu_if #(.WIDTH(W)) bus();

    calc_alu #(.WIDTH(W), .MAX_VALUE(9999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(int a, int b, int op);
        exp_t e;
        int ca, cb, r;
        ca = (a > 9999) ? 9999 : a;
        cb = (b > 9999) ? 9999 : b;
        e.err = 1'b0;
        e.lat = 2;
        r = 0;
        case (op)
            0: begin
                r = ca + cb;
                if (r > 9999) begin r = 9999; e.err = 1'b1; end
            end
            1: begin
                if (ca < cb) begin r = 0; e.err = 1'b1; end
                else r = ca - cb;
            end
            2: begin
                e.lat = 15;
                r = ca * cb;
                if (r > 9999) begin r = 9999; e.err = 1'b1; end
            end
            default: begin
                if (cb == 0) begin r = 0; e.err = 1'b1; end
                else begin r = ca / cb; e.lat = 15; end
            end
        endcase
        e.res = W'(r);
        return e;
    endfunction

    // Present one request for a single accepting edge, then scramble the
    // inputs so a late capture would show up as a wrong result.
    task automatic drive_op(input int a, input int b, input int op);
        @(negedge clk);
        bus.operand_a = W'(a);
        bus.operand_b = W'(b);
        bus.op        = 2'(op);
        bus.start     = 1'b1;
        sb.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = W'($urandom);
        bus.operand_b = W'($urandom);
        bus.op        = 2'($urandom);
    endtask

    // Count edges after acceptance until done; optionally pokes start+clear
    // high for two cycles beginning at edge 'poke'.
    task automatic wait_done(input int poke, output logic [W-1:0] r,
                             output logic e, output int lat, output bit tmo);
        lat = 0;
        tmo = 1'b1;
        r   = '0;
        e   = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == poke) begin bus.start = 1'b1; bus.clear = 1'b1; end
            if (lat == poke + 2) begin bus.start = 1'b0; bus.clear = 1'b0; end
            if (bus.done === 1'b1) begin
                tmo = 1'b0;
                r   = bus.result;
                e   = bus.error;
                break;
            end
        end
        bus.start = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000 || bus.result !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%0d error=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.error);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addsub();
        int ta[5] = '{5000, 5000, 12, 30, 16383};
        int tb[5] = '{4999, 5000, 30, 12, 0};
        int to[5] = '{0, 0, 1, 1, 0};
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        for (int i = 0; i < 5; i++) begin
            drive_op(ta[i], tb[i], to[i]);
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL addsub[%0d] busy_after_accept: got %b want 1", i, bus.busy);
            end
            wait_done(-10, r, e, lat, tmo);
            x = sb.pop_front();
            n_cmp++;
            if (tmo) begin
                n_bad++;
                $display("FAIL addsub[%0d] timeout: no done within 40 cycles", i);
            end else begin
                if (r !== x.res || e !== x.err || lat !== x.lat) begin
                    n_bad++;
                    $display("FAIL addsub[%0d]: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                             i, r, e, lat, x.res, x.err, x.lat);
                end
            end
        end
    endtask

    task automatic test_mul();
        int ta[4] = '{99, 100, 0, 123};
        int tb[4] = '{101, 100, 9999, 45};
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        for (int i = 0; i < 4; i++) begin
            drive_op(ta[i], tb[i], 2);
            wait_done(-10, r, e, lat, tmo);
            x = sb.pop_front();
            n_cmp++;
            if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
                n_bad++;
                $display("FAIL mul[%0d] tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                         i, tmo, r, e, lat, x.res, x.err, x.lat);
            end
        end
    endtask

    task automatic test_div();
        int ta[5] = '{9999, 7, 9999, 42, 1000};
        int tb[5] = '{7, 9999, 1, 0, 33};
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        for (int i = 0; i < 5; i++) begin
            drive_op(ta[i], tb[i], 3);
            wait_done(-10, r, e, lat, tmo);
            x = sb.pop_front();
            n_cmp++;
            if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
                n_bad++;
                $display("FAIL div[%0d] tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                         i, tmo, r, e, lat, x.res, x.err, x.lat);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        int a, b, op;
        for (int i = 0; i < 8; i++) begin
            a  = int'($urandom_range(0, 16383));
            b  = int'($urandom_range(0, 200));
            op = int'($urandom_range(0, 3));
            drive_op(a, b, op);
            wait_done(-10, r, e, lat, tmo);
            x = sb.pop_front();
            n_cmp++;
            if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
                n_bad++;
                $display("FAIL random[%0d] a=%0d b=%0d op=%0d tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                         i, a, b, op, tmo, r, e, lat, x.res, x.err, x.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        int seen;
        drive_op(123, 45, 2);
        void'(sb.pop_front());
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000 || bus.result !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b result=%0d error=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.error);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid_abort: %0d cycles with done/busy set, want 0", seen);
        end
        drive_op(12, 12, 2);
        wait_done(-10, r, e, lat, tmo);
        x = sb.pop_front();
        n_cmp++;
        if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
            n_bad++;
            $display("FAIL reset_mid_next tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                     tmo, r, e, lat, x.res, x.err, x.lat);
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        int seen;
        drive_op(50, 3, 2);
        bus.operand_a = W'(1);
        bus.operand_b = W'(1);
        bus.op        = 2'b00;
        wait_done(3, r, e, lat, tmo);
        x = sb.pop_front();
        n_cmp++;
        if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
            n_bad++;
            $display("FAIL busy_ignore tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                     tmo, r, e, lat, x.res, x.err, x.lat);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== W'(150)) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL busy_ignore_after: %0d bad idle cycles, result=%0d want 150", seen, bus.result);
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] r; logic e; int lat; bit tmo; exp_t x;
        drive_op(42, 0, 3);
        wait_done(-10, r, e, lat, tmo);
        x = sb.pop_front();
        n_cmp++;
        if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
            n_bad++;
            $display("FAIL div_zero tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                     tmo, r, e, lat, x.res, x.err, x.lat);
        end
        // Leave a nonzero result so the clear is observable.
        drive_op(20, 5, 0);
        wait_done(-10, r, e, lat, tmo);
        void'(sb.pop_front());
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        n_cmp++;
        if (bus.result !== '0 || bus.error !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_idle: result=%0d error=%b want 0/0", bus.result, bus.error);
        end
        // start and clear together: start wins.
        @(negedge clk);
        bus.operand_a = W'(7);
        bus.operand_b = W'(8);
        bus.op        = 2'b00;
        bus.start     = 1'b1;
        bus.clear     = 1'b1;
        sb.push_back(model(7, 8, 0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_clear_busy: got %b want 1", bus.busy);
        end
        wait_done(-10, r, e, lat, tmo);
        x = sb.pop_front();
        n_cmp++;
        if (tmo || r !== x.res || e !== x.err || lat !== x.lat) begin
            n_bad++;
            $display("FAIL start_clear tmo=%b: got res=%0d err=%b lat=%0d want res=%0d err=%b lat=%0d",
                     tmo, r, e, lat, x.res, x.err, x.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; logic e; int lat; bit tmo;
        logic want;
        @(negedge clk);
        bus.operand_a = W'(1);
        bus.operand_b = W'(2);
        bus.op        = 2'b00;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            want = ((k % 3) == 2);
            n_cmp++;
            if (bus.done !== want || (want && bus.result !== W'(3))) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d: done=%b result=%0d want done=%b result=3",
                         k, bus.done, bus.result, want);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(-10, r, e, lat, tmo);
    endtask

    initial begin
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.op        = '0;
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_random();
        test_reset_mid();
        test_busy_ignore();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/calc_alu.md
# calc_alu

Sequential arithmetic unit for the calculator datapath: accepts two decimal-range operands and an operation code, computes add, subtract, multiply or divide, and holds a saturated 14-bit result. `result` drives the `number` input of the four-digit display multiplexer directly. Multiply and divide are iterative (one bit per cycle) to keep area small. A start/busy/done handshake connects it to the keypad/control FSM.

## Interface

**Parameters**
- `WIDTH`, 14 — operand and result width.
- `MAX_VALUE`, 9999 — largest displayable value; saturation ceiling.

**Ports**
- `clk`  in  1 — system clock; all state on rising edge.
- `reset`  in  1 — one clock; reset is asynchronous and active-low.
- `operand_a`  in  WIDTH — first operand, unsigned.
- `operand_b`  in  WIDTH — second operand, unsigned.
- `op`  in  2 — operation select: 00 add, 01 sub (a−b), 10 mul, 11 div (a/b).
- `start`  in  1 — request; sampled only in IDLE.
- `clear`  in  1 — zero `result` and `error`; honoured only in IDLE.
- `busy`  out  1 — high from the edge after `start` is accepted until `done`.
- `done`  out  1 — one-cycle pulse; `result`/`error` valid and updated on the same edge.
- `result`  out  WIDTH — held result, 0..MAX_VALUE.
- `error`  out  1 — held flag: saturation, negative result, or divide by zero.

## Operation

- **States:** IDLE, ADDSUB, MUL, DIV, FINISH.
- **IDLE + `start`:**
  - Capture operands, clamping any value above MAX_VALUE to MAX_VALUE.
  - Capture `op`; clear the iteration counter.
  - Go to ADDSUB (op 0x), MUL or DIV.
- **IDLE + `clear` (no `start`):** `result`←0, `error`←0 on the next edge. If `start` and `clear` are high together, `start` wins and `clear` is ignored.
- **ADDSUB:**
  - Compute in WIDTH+1 bits.
  - Add: sum > MAX_VALUE → `result`=MAX_VALUE, `error`=1; otherwise `result`=sum, `error`=0.
  - Sub: a < b → `result`=0, `error`=1; otherwise `result`=a−b, `error`=0.
  - Go to FINISH.
- **MUL:**
  - Shift-add over the 2·WIDTH-bit product, one multiplier bit per cycle, LSB first.
  - Exactly WIDTH iterations, then FINISH.
  - Product > MAX_VALUE → `result`=MAX_VALUE, `error`=1.
- **DIV:**
  - Restoring division, one quotient bit per cycle, MSB first, WIDTH iterations, then FINISH.
  - `result`=quotient; remainder discarded; `error`=0.
  - b == 0 is detected on the first DIV cycle: go straight to FINISH with `result`=0, `error`=1, no iterations.
- **FINISH:** Write `result`/`error`, pulse `done`, drop `busy`, return to IDLE.
- **Holding:** `result` and `error` change only on `done` or an honoured `clear`. The display stays stable during computation.
- **Ignored inputs:** `start` and `clear` while not in IDLE; operand and `op` changes after capture.

## Timing

- **Reset (asynchronous, `reset`=0):** state IDLE, `busy`=0, `done`=0, `result`=0, `error`=0, counter=0. Takes effect immediately, including mid-operation. The operation is aborted with no `done`.
- **Acceptance:** `start` sampled high at edge N → `busy`=1 after edge N.
- **Add/sub:** ADDSUB at N+1, FINISH at N+2. `done`=1 for the cycle following edge N+2. Latency 2 edges, 3 cycles start-to-done.
- **Mul/div:**
  - Iterations on edges N+1..N+WIDTH, FINISH at edge N+WIDTH+1.
  - `done` follows edge N+WIDTH+1 (N+15 for WIDTH=14). Latency is fixed and independent of operand values.
- **Divide by zero:** `done` follows edge N+2.
- **Back-to-back:**
  - `busy` falls and `done` rises on the same edge; the block is in IDLE during the `done` cycle.
  - `start` held high during `done` is accepted at that cycle's closing edge.
  - Minimum issue interval is 3 cycles.
- **`done`:** never high for more than one consecutive cycle.

## Test plan

- **Reset mid-multiply:** start mul 123×45, assert `reset` low at iteration 7 → all outputs 0 immediately, no `done` pulse, then 12×12 returns 144 with `done` at N+15.
- **Add/sub saturation and latency:** 5000+4999 → 9999/`error`=0, `done` at N+2. 5000+5000 → 9999/`error`=1. 12−30 → 0/`error`=1. 30−12 → 18/`error`=0.
- **Multiply:** 99×101 → 9999/`error`=0. 100×100 → 9999/`error`=1. 0×9999 → 0. Each `done` exactly 15 cycles after acceptance.
- **Divide:** 9999/7 → 1428. 7/9999 → 0. 9999/1 → 9999. 42/0 → 0/`error`=1 with `done` at N+2.
- **Handshake:**
  - `start` pulsed while `busy` is ignored; result matches the first request only.
  - `start` held high continuously issues one operation every 3 cycles for add.
  - `clear` during `busy` is ignored; `clear` in IDLE zeroes `result`/`error` next edge.
- **Operand clamp:** `operand_a`=16383, `operand_b`=0, add → result 9999, `error`=0.
